// File: rtl/fft_result_checker_pkg.sv
// Shared definitions for the FFT result checker: sizing helper and FSM encoding.
package fft_result_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_JUDGE   = 2'd3
  } fsm_state_e;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fft_cmp_stage.sv
// One registered compare stage: flags a sample whose real or imaginary part
// differs from the golden value by more than TOL LSBs.
module fft_cmp_stage #(
  parameter int WIDTH = 18,
  parameter int IDX_W = 5,
  parameter int TOL   = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] dat_re_i,
  input  logic [WIDTH-1:0] dat_im_i,
  input  logic [WIDTH-1:0] gold_re_i,
  input  logic [WIDTH-1:0] gold_im_i,
  output logic             valid_o,
  output logic             mis_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int W1 = WIDTH + 1;
  localparam logic [WIDTH:0] TOL_C = W1'(TOL);

  logic [WIDTH:0]   diff_re, diff_im, mag_re, mag_im;
  logic             mis;
  logic             valid_q, mis_q;
  logic [IDX_W-1:0] idx_q;

  // One guard bit keeps the difference of two full-range values from wrapping.
  always_comb begin
    diff_re = {dat_re_i[WIDTH-1], dat_re_i} - {gold_re_i[WIDTH-1], gold_re_i};
    diff_im = {dat_im_i[WIDTH-1], dat_im_i} - {gold_im_i[WIDTH-1], gold_im_i};
    mag_re  = diff_re[WIDTH] ? (~diff_re + 1'b1) : diff_re;
    mag_im  = diff_im[WIDTH] ? (~diff_im + 1'b1) : diff_im;
    mis     = (mag_re > TOL_C) || (mag_im > TOL_C);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_i;
      mis_q   <= mis;
      idx_q   <= idx_i;
    end
  end

  assign valid_o = valid_q;
  assign mis_o   = mis_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/fft_result_checker.sv
// Compares each FFT output frame against a selected golden set held in an
// external synchronous memory and publishes a per-frame verdict and statistics.
module fft_result_checker
  import fft_result_checker_pkg::*;
#(
  parameter int  POINTS   = 32,
  parameter int  WIDTH    = 18,
  parameter int  NUM_SETS = 2,
  parameter int  TOL      = 0,
  localparam int LOGPTS   = ceil_log2(POINTS),
  localparam int LOGSETS  = (ceil_log2(NUM_SETS) < 1) ? 1 : ceil_log2(NUM_SETS)
) (
  input  logic                      CLK,
  input  logic                      NGRST,
  input  logic                      CLR,
  input  logic [WIDTH-1:0]          DATAO_RE,
  input  logic [WIDTH-1:0]          DATAO_IM,
  input  logic                      DATAO_VALID,
  input  logic                      OUTP_READY,
  input  logic [LOGSETS-1:0]        SET_SEL,
  output logic [LOGSETS+LOGPTS-1:0] GOLD_ADDR,
  input  logic [WIDTH-1:0]          GOLD_RE,
  input  logic [WIDTH-1:0]          GOLD_IM,
  output logic                      FRAME_DONE,
  output logic                      FRAME_PASS,
  output logic [LOGPTS:0]           ERR_CNT,
  output logic [LOGPTS-1:0]         FIRST_ERR_IDX,
  output logic [15:0]               FRAMES_CHECKED,
  output logic                      ANY_FAIL,
  output logic [1:0]                DBG_STATE
);

  localparam int CNT_W = LOGPTS + 1;
  localparam int AW    = LOGSETS + LOGPTS;
  localparam logic [CNT_W-1:0] PTS_C = CNT_W'(POINTS);
  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(POINTS + 1);

  fsm_state_e state_q, state_d;
  logic       issue, fall;

  logic                 ready_prev_q, ready_prev_d;
  logic [CNT_W-1:0]     idx_q, idx_d, issue_idx;
  logic [LOGSETS-1:0]   set_q, set_d, issue_set;
  logic [AW-1:0]        gold_addr_q, gold_addr_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [LOGPTS-1:0]    s1_idx_q, s1_idx_d;
  logic [WIDTH-1:0]     s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic [CNT_W-1:0]     err_acc_q, err_acc_d;
  logic [LOGPTS-1:0]    first_acc_q, first_acc_d;
  logic                 found_q, found_d;
  logic                 done_q, done_d, pass_q, pass_d, any_fail_q, any_fail_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [LOGPTS-1:0]    first_err_q, first_err_d;
  logic [15:0]          frames_q, frames_d;

  logic                 cmp_valid, cmp_mis;
  logic [LOGPTS-1:0]    cmp_idx;

  // DATAO_VALID qualifies one sample per cycle; there is no backpressure, so a
  // sample is consumed in exactly the cycle it is presented while a frame is open.
  assign fall = ready_prev_q & ~OUTP_READY;

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (DATAO_VALID && OUTP_READY) begin
          issue   = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        issue = DATAO_VALID;
        if (fall) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_JUDGE;
      ST_JUDGE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (CLR) begin
      state_d = ST_IDLE;
      issue   = 1'b0;
    end
  end

  always_comb begin
    issue_idx    = (state_q == ST_IDLE) ? '0 : idx_q;
    issue_set    = (state_q == ST_IDLE) ? SET_SEL : set_q;
    GOLD_ADDR    = issue ? {issue_set, issue_idx[LOGPTS-1:0]} : gold_addr_q;
    gold_addr_d  = GOLD_ADDR;
    ready_prev_d = OUTP_READY;
    idx_d        = idx_q;
    set_d        = set_q;
    if (issue) begin
      set_d = issue_set;
      idx_d = (issue_idx == SAT_C) ? SAT_C : issue_idx + 1'b1;
    end

    // Sample is held one cycle so it meets the golden word read for its address.
    s1_valid_d = issue && (issue_idx < PTS_C);
    s1_idx_d   = issue_idx[LOGPTS-1:0];
    s1_re_d    = issue ? DATAO_RE : s1_re_q;
    s1_im_d    = issue ? DATAO_IM : s1_im_q;

    err_acc_d   = err_acc_q;
    first_acc_d = first_acc_q;
    found_d     = found_q;
    if (issue && (state_q == ST_IDLE)) begin
      err_acc_d   = '0;
      first_acc_d = '0;
      found_d     = 1'b0;
    end else if (cmp_valid && cmp_mis) begin
      if (err_acc_q != PTS_C) err_acc_d = err_acc_q + 1'b1;
      if (!found_q) begin
        found_d     = 1'b1;
        first_acc_d = cmp_idx;
      end
    end

    // The last sample's compare result lands during JUDGE, so publish the next-state tally.
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    frames_d    = frames_q;
    any_fail_d  = any_fail_q;
    if (state_q == ST_JUDGE) begin
      done_d      = 1'b1;
      pass_d      = (err_acc_d == '0) && (idx_q == PTS_C);
      err_cnt_d   = err_acc_d;
      first_err_d = first_acc_d;
      frames_d    = (frames_q == 16'hFFFF) ? frames_q : frames_q + 16'd1;
      any_fail_d  = any_fail_q | ~pass_d;
    end

    if (CLR) begin
      gold_addr_d  = '0;
      ready_prev_d = 1'b0;
      idx_d        = '0;
      set_d        = '0;
      s1_valid_d   = 1'b0;
      s1_idx_d     = '0;
      s1_re_d      = '0;
      s1_im_d      = '0;
      err_acc_d    = '0;
      first_acc_d  = '0;
      found_d      = 1'b0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      err_cnt_d    = '0;
      first_err_d  = '0;
      frames_d     = '0;
      any_fail_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      gold_addr_q  <= '0;
      ready_prev_q <= 1'b0;
      idx_q        <= '0;
      set_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      s1_re_q      <= '0;
      s1_im_q      <= '0;
      err_acc_q    <= '0;
      first_acc_q  <= '0;
      found_q      <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      frames_q     <= '0;
      any_fail_q   <= 1'b0;
    end else begin
      gold_addr_q  <= gold_addr_d;
      ready_prev_q <= ready_prev_d;
      idx_q        <= idx_d;
      set_q        <= set_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      s1_re_q      <= s1_re_d;
      s1_im_q      <= s1_im_d;
      err_acc_q    <= err_acc_d;
      first_acc_q  <= first_acc_d;
      found_q      <= found_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      first_err_q  <= first_err_d;
      frames_q     <= frames_d;
      any_fail_q   <= any_fail_d;
    end
  end

  fft_cmp_stage #(
    .WIDTH (WIDTH),
    .IDX_W (LOGPTS),
    .TOL   (TOL)
  ) u_cmp (
    .clk_i     (CLK),
    .rst_ni    (NGRST),
    .clr_i     (CLR),
    .valid_i   (s1_valid_q),
    .idx_i     (s1_idx_q),
    .dat_re_i  (s1_re_q),
    .dat_im_i  (s1_im_q),
    .gold_re_i (GOLD_RE),
    .gold_im_i (GOLD_IM),
    .valid_o   (cmp_valid),
    .mis_o     (cmp_mis),
    .idx_o     (cmp_idx)
  );

  assign FRAME_DONE     = done_q;
  assign FRAME_PASS     = pass_q;
  assign ERR_CNT        = err_cnt_q;
  assign FIRST_ERR_IDX  = first_err_q;
  assign FRAMES_CHECKED = frames_q;
  assign ANY_FAIL       = any_fail_q;
  assign DBG_STATE      = state_q;

endmodule

// File: tb/tb_fft_result_checker.sv
// Bench for fft_result_checker: two instances (TOL=0 and TOL=1) share one
// stimulus stream and are judged against a frame-level reference model.
module tb_fft_result_checker;

  localparam int POINTS   = 32;
  localparam int WIDTH    = 18;
  localparam int NUM_SETS = 2;
  localparam int AW       = 6;

  logic             clk, ngrst, clr, valid, ready;
  logic [0:0]       set_sel;
  logic [WIDTH-1:0] dre, dim;
  logic [AW-1:0]    addr0, addr1;
  logic [WIDTH-1:0] gre0, gim0, gre1, gim1;
  logic             done0, pass0, any0, done1, pass1, any1;
  logic [5:0]       err0, err1;
  logic [4:0]       first0, first1;
  logic [15:0]      fc0, fc1;
  logic [1:0]       st0, st1;

  logic [WIDTH-1:0] g_re [NUM_SETS*POINTS];
  logic [WIDTH-1:0] g_im [NUM_SETS*POINTS];
  logic [WIDTH-1:0] fr_re [64];
  logic [WIDTH-1:0] fr_im [64];
  int               fr_n;
  logic [AW-1:0]    exp_q[$];

  int checks, failures, exp_frames;
  bit exp_any0, exp_any1;

  fft_result_checker #(.POINTS(POINTS), .WIDTH(WIDTH), .NUM_SETS(NUM_SETS), .TOL(0)) u_dut0 (
    .CLK(clk), .NGRST(ngrst), .CLR(clr), .DATAO_RE(dre), .DATAO_IM(dim),
    .DATAO_VALID(valid), .OUTP_READY(ready), .SET_SEL(set_sel), .GOLD_ADDR(addr0),
    .GOLD_RE(gre0), .GOLD_IM(gim0), .FRAME_DONE(done0), .FRAME_PASS(pass0),
    .ERR_CNT(err0), .FIRST_ERR_IDX(first0), .FRAMES_CHECKED(fc0), .ANY_FAIL(any0),
    .DBG_STATE(st0)
  );

  fft_result_checker #(.POINTS(POINTS), .WIDTH(WIDTH), .NUM_SETS(NUM_SETS), .TOL(1)) u_dut1 (
    .CLK(clk), .NGRST(ngrst), .CLR(clr), .DATAO_RE(dre), .DATAO_IM(dim),
    .DATAO_VALID(valid), .OUTP_READY(ready), .SET_SEL(set_sel), .GOLD_ADDR(addr1),
    .GOLD_RE(gre1), .GOLD_IM(gim1), .FRAME_DONE(done1), .FRAME_PASS(pass1),
    .ERR_CNT(err1), .FIRST_ERR_IDX(first1), .FRAMES_CHECKED(fc1), .ANY_FAIL(any1),
    .DBG_STATE(st1)
  );

  // Clock and golden memories (one-cycle read latency)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    gre0 <= g_re[addr0];
    gim0 <= g_im[addr0];
    gre1 <= g_re[addr1];
    gim1 <= g_im[addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model
  function automatic int absd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int d;
    d = int'($signed(a)) - int'($signed(b));
    return (d < 0) ? -d : d;
  endfunction

  function automatic void judge(input int set, input int tol, output bit pass,
                                output int errs, output int first);
    errs  = 0;
    first = 0;
    for (int i = 0; i < fr_n && i < POINTS; i++) begin
      if (absd(fr_re[i], g_re[set*POINTS+i]) > tol || absd(fr_im[i], g_im[set*POINTS+i]) > tol) begin
        if (errs == 0) first = i;
        errs++;
      end
    end
    pass = (errs == 0) && (fr_n == POINTS);
  endfunction

  task automatic build_frame(input int set, input int n);
    fr_n = n;
    for (int i = 0; i < n; i++) begin
      fr_re[i] = g_re[set*POINTS + (i % POINTS)];
      fr_im[i] = g_im[set*POINTS + (i % POINTS)];
    end
  endtask

  // Scoreboard for one verdict window
  task automatic wait_verdict(input int set, input bit expect_done);
    bit p0, p1;
    int e0, e1, f0, f1, pulses0, pulses1;
    pulses0 = 0;
    pulses1 = 0;
    judge(set, 0, p0, e0, f0);
    judge(set, 1, p1, e1, f1);
    if (expect_done) begin
      if (exp_frames < 65535) exp_frames++;
      exp_any0 = exp_any0 | !p0;
      exp_any1 = exp_any1 | !p1;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done0) begin
        pulses0++;
        check("pass_t0", pass0, p0);
        check("err_cnt_t0", err0, e0);
        check("first_idx_t0", first0, f0);
      end
      if (done1) begin
        pulses1++;
        check("pass_t1", pass1, p1);
        check("err_cnt_t1", err1, e1);
        check("first_idx_t1", first1, f1);
      end
    end
    tick();
    check("done_pulses_t0", pulses0, expect_done);
    check("done_pulses_t1", pulses1, expect_done);
    check("frames_t0", fc0, exp_frames);
    check("frames_t1", fc1, exp_frames);
    check("any_fail_t0", any0, exp_any0);
    check("any_fail_t1", any1, exp_any1);
  endtask

  // Driver for one full frame
  task automatic run_frame(input int set, input bit gapped, input bit coincident);
    logic [AW-1:0] last_addr, e;
    int  i, k;
    bit  toggle_now;
    for (int j = 0; j < fr_n; j++) exp_q.push_back({1'(set), 5'(j % POINTS)});
    set_sel = 1'(set);
    ready   = 1'b1;
    valid   = 1'b0;
    tick();
    i = 0;
    k = 0;
    last_addr  = '0;
    toggle_now = 1'b0;
    while (i < fr_n) begin
      if (gapped && (k % 4 == 3)) begin
        valid = 1'b0;
        @(negedge clk);
        check("gold_addr_hold", addr0, last_addr);
      end else begin
        valid = 1'b1;
        dre   = fr_re[i];
        dim   = fr_im[i];
        if (coincident && i == fr_n - 1) ready = 1'b0;
        e = exp_q.pop_front();
        last_addr = e;
        @(negedge clk);
        check("gold_addr", addr0, e);
        toggle_now = (i == 0);
        i++;
      end
      tick();
      k++;
      if (toggle_now) begin
        set_sel    = ~set_sel;
        toggle_now = 1'b0;
      end
    end
    valid = 1'b0;
    ready = 1'b0;
    wait_verdict(set, 1'b1);
  endtask

  task automatic drive_partial(input int set, input int m);
    set_sel = 1'(set);
    ready   = 1'b1;
    valid   = 1'b0;
    tick();
    for (int i = 0; i < m; i++) begin
      valid = 1'b1;
      dre   = fr_re[i];
      dim   = fr_im[i];
      tick();
    end
    valid = 1'b0;
  endtask

  initial begin
    int rs, r, n, nerr, idx, delta;
    checks = 0; failures = 0; exp_frames = 0; exp_any0 = 1'b0; exp_any1 = 1'b0;
    ngrst = 1'b0; clr = 1'b0; valid = 1'b0; ready = 1'b0; set_sel = 1'b0;
    dre = '0; dim = '0; fr_n = 0;
    for (int i = 0; i < NUM_SETS*POINTS; i++) begin
      g_re[i] = 18'($urandom);
      g_im[i] = 18'($urandom);
    end
    g_re[7] = 18'h1FFFF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err_cnt", err0, 0);
    check("rst_first_idx", first0, 0);
    check("rst_frames", fc0, 0);
    check("rst_any_fail", any0, 0);
    check("rst_gold_addr", addr0, 0);
    check("rst_state_t0", st0, 0);
    check("rst_state_t1", st1, 0);
    @(posedge clk);
    #1;
    ngrst = 1'b1;
    tick();

    // Exact frame, then the same frame with two 1-LSB errors
    build_frame(0, POINTS);
    run_frame(0, 1'b0, 1'b0);
    build_frame(0, POINTS);
    fr_re[5]  = fr_re[5] + 18'd1;
    fr_re[20] = fr_re[20] + 18'd1;
    run_frame(0, 1'b0, 1'b0);

    // Short and long frames
    build_frame(1, POINTS - 1);
    run_frame(1, 1'b0, 1'b0);
    build_frame(0, POINTS + 1);
    run_frame(0, 1'b1, 1'b0);

    // Full-scale difference that would wrap in WIDTH bits
    build_frame(0, POINTS);
    fr_re[7] = 18'h20000;
    run_frame(0, 1'b0, 1'b0);

    // Alternating sets, gapped valid, last sample on the ready fall
    for (int f = 0; f < 4; f++) begin
      build_frame(f % 2, POINTS);
      run_frame(f % 2, 1'b1, 1'b1);
    end

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      rs = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 5));
      n  = (r == 0) ? POINTS - 1 : ((r == 1) ? POINTS + 1 : POINTS);
      build_frame(rs, n);
      nerr = int'($urandom_range(0, 3));
      for (int j = 0; j < nerr; j++) begin
        idx   = int'($urandom_range(0, 32'(n - 1)));
        delta = int'($urandom_range(0, 4)) - 2;
        if ($urandom_range(0, 1) == 1) fr_re[idx] = fr_re[idx] + 18'(delta);
        else                           fr_im[idx] = fr_im[idx] + 18'(delta);
      end
      run_frame(rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Ready pulse without any valid sample
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    wait_verdict(0, 1'b0);

    // Reset in the middle of a frame
    build_frame(0, POINTS);
    drive_partial(0, 10);
    ngrst = 1'b0;
    ready = 1'b0;
    exp_frames = 0; exp_any0 = 1'b0; exp_any1 = 1'b0;
    @(negedge clk);
    check("midrst_frames", fc0, 0);
    check("midrst_state", st0, 0);
    check("midrst_gold_addr", addr0, 0);
    tick();
    ngrst = 1'b1;
    tick();
    run_frame(0, 1'b1, 1'b0);

    // Failing frame, then clear in the middle of the next frame
    build_frame(1, POINTS - 1);
    run_frame(1, 1'b0, 1'b0);
    build_frame(1, POINTS);
    drive_partial(1, 10);
    clr   = 1'b1;
    ready = 1'b0;
    tick();
    clr = 1'b0;
    exp_frames = 0; exp_any0 = 1'b0; exp_any1 = 1'b0;
    wait_verdict(1, 1'b0);
    check("clr_err_cnt", err0, 0);
    check("clr_pass", pass0, 0);
    check("clr_first_idx", first0, 0);
    check("clr_gold_addr", addr0, 0);
    check("clr_state", st0, 0);

    build_frame(1, POINTS);
    run_frame(1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
